// File: rtl/decode_stage.sv
// Decode stage of the RV32I-subset pipeline.
// This module contains the 32x32 register file with write-first bypass, the
// main decoder and the immediate sign-extension. Everything it decodes is
// registered into the Decode/Execute pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr_D,
    input  logic [31:0] RF_WD_D,
    input  logic        RF_write,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Extend_E,
    output logic [1:0]  Alu_op_E,
    output logic        Alu_src_E,
    output logic        DM_Write_E,
    output logic        Result_E,
    output logic        RF_WE_E
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_fmt_t;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        unused_funct3;

    logic [31:0] regs [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        rf_we;
    logic        alu_src;
    logic        dm_write;
    logic        result_sel;
    logic [1:0]  alu_op;
    imm_fmt_t    imm_fmt;
    logic signed [31:0] imm;

    assign opcode        = Instr_D[6:0];
    assign rd            = Instr_D[11:7];
    assign rs1           = Instr_D[19:15];
    assign rs2           = Instr_D[24:20];
    // funct3 is resolved in Execute.
    assign unused_funct3 = ^Instr_D[14:12];

    function automatic logic signed [31:0] sext_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [31:0] sext_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [31:0] sext_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    // Register-file writes; reset clears every entry and blocks the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RF_write && rd != 5'd0) begin
            regs[rd] <= RF_WD_D;
        end
    end

    // Combinational reads with x0 hardwired and write-first bypass.
    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (RF_write && rd == rs1) rd1 = RF_WD_D;
        if (RF_write && rd == rs2) rd2 = RF_WD_D;
        if (rs1 == 5'd0) rd1 = '0;
        if (rs2 == 5'd0) rd2 = '0;
    end

    // Main decoder: opcode to control bits and immediate format.
    always_comb begin
        rf_we      = 1'b0;
        alu_src    = 1'b0;
        dm_write   = 1'b0;
        result_sel = 1'b0;
        alu_op     = 2'b00;
        imm_fmt    = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                rf_we  = 1'b1;
                alu_op = 2'b10;
            end
            OP_IALU: begin
                rf_we   = 1'b1;
                alu_src = 1'b1;
                alu_op  = 2'b10;
                imm_fmt = IMM_I;
            end
            OP_LOAD: begin
                rf_we      = 1'b1;
                alu_src    = 1'b1;
                result_sel = 1'b1;
                imm_fmt    = IMM_I;
            end
            OP_STORE: begin
                alu_src  = 1'b1;
                dm_write = 1'b1;
                imm_fmt  = IMM_S;
            end
            OP_BRANCH: begin
                alu_op  = 2'b01;
                imm_fmt = IMM_B;
            end
            default: ;
        endcase
    end

    // Immediate extension for the selected format.
    always_comb begin
        case (imm_fmt)
            IMM_I:   imm = sext_i(Instr_D);
            IMM_S:   imm = sext_s(Instr_D);
            IMM_B:   imm = sext_b(Instr_D);
            default: imm = '0;
        endcase
    end

    // Decode/Execute pipeline register; loads every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            RD1_E      <= '0;
            RD2_E      <= '0;
            Extend_E   <= '0;
            Alu_op_E   <= '0;
            Alu_src_E  <= 1'b0;
            DM_Write_E <= 1'b0;
            Result_E   <= 1'b0;
            RF_WE_E    <= 1'b0;
        end else begin
            RD1_E      <= rd1;
            RD2_E      <= rd2;
            Extend_E   <= imm;
            Alu_op_E   <= alu_op;
            Alu_src_E  <= alu_src;
            DM_Write_E <= dm_write;
            Result_E   <= result_sel;
            RF_WE_E    <= rf_we;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed instructions with hand-computed
// expectations, queued by the driver and checked by an independent monitor.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr_D;
    logic [31:0] RF_WD_D;
    logic        RF_write;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Extend_E;
    logic [1:0]  Alu_op_E;
    logic        Alu_src_E;
    logic        DM_Write_E;
    logic        Result_E;
    logic        RF_WE_E;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [1:0]  aluop;
        logic        src;
        logic        dmw;
        logic        res;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .Instr_D    (Instr_D),
        .RF_WD_D    (RF_WD_D),
        .RF_write   (RF_write),
        .RD1_E      (RD1_E),
        .RD2_E      (RD2_E),
        .Extend_E   (Extend_E),
        .Alu_op_E   (Alu_op_E),
        .Alu_src_E  (Alu_src_E),
        .DM_Write_E (DM_Write_E),
        .Result_E   (Result_E),
        .RF_WE_E    (RF_WE_E)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(string n, logic [31:0] rd1, logic [31:0] rd2,
                                logic [31:0] ext, logic [1:0] aluop, logic src,
                                logic dmw, logic res, logic we);
        exp_t e;
        e.name = n; e.rd1 = rd1; e.rd2 = rd2; e.ext = ext; e.aluop = aluop;
        e.src = src; e.dmw = dmw; e.res = res; e.we = we;
        return e;
    endfunction

    task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", n, f, act, req);
        end
    endtask

    // Apply inputs, let the edge capture them, then queue the expected response.
    task automatic issue(logic r, logic [31:0] ins, logic we, logic [31:0] wd, exp_t e);
        rst = r; Instr_D = ins; RF_write = we; RF_WD_D = wd;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    // Monitor: the outputs captured at the last edge are checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "RD1_E",      RD1_E,               e.rd1);
            cmp(e.name, "RD2_E",      RD2_E,               e.rd2);
            cmp(e.name, "Extend_E",   Extend_E,            e.ext);
            cmp(e.name, "Alu_op_E",   {30'd0, Alu_op_E},   {30'd0, e.aluop});
            cmp(e.name, "Alu_src_E",  {31'd0, Alu_src_E},  {31'd0, e.src});
            cmp(e.name, "DM_Write_E", {31'd0, DM_Write_E}, {31'd0, e.dmw});
            cmp(e.name, "Result_E",   {31'd0, Result_E},   {31'd0, e.res});
            cmp(e.name, "RF_WE_E",    {31'd0, RF_WE_E},    {31'd0, e.we});
        end
    end

    localparam logic [31:0] BEEF = 32'hDEADBEEF;
    localparam logic [31:0] K    = 32'h12345678;

    initial begin
        int budget;
        rst = 1'b1; Instr_D = '0; RF_write = 1'b0; RF_WD_D = '0;

        // Reset for two edges; the attempted write to x6 must be suppressed.
        issue(1, 32'h00208333, 1, 32'hFFFFFFFF, mk("reset0", 0, 0, 0, 2'b00, 0, 0, 0, 0));
        issue(1, 32'h00208333, 1, 32'hFFFFFFFF, mk("reset1", 0, 0, 0, 2'b00, 0, 0, 0, 0));

        // R-type variants share control outputs.
        issue(0, 32'h00208333, 0, 0, mk("add",  0, 0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h40208333, 0, 0, mk("sub",  0, 0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h0020f333, 0, 0, mk("and",  0, 0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h00030033, 0, 0, mk("rd_x6_after_reset", 0, 0, 0, 2'b10, 0, 0, 0, 1));

        // I-ALU immediates, positive and negative.
        issue(0, 32'h00918113, 0, 0, mk("addi9",  0, 0, 32'h00000009, 2'b10, 1, 0, 0, 1));
        issue(0, 32'hFFF00093, 0, 0, mk("addi-1", 0, 0, 32'hFFFFFFFF, 2'b10, 1, 0, 0, 1));

        // Write x1, then read it back; write to x0 is ignored (also not bypassed).
        issue(0, 32'h000000B3, 1, BEEF,          mk("wr_x1",  0,    0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h00008133, 0, 0,             mk("rd_x1",  BEEF, 0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h00000033, 1, 32'hCAFEF00D,  mk("wr_x0",  0,    0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h00000033, 0, 0,             mk("rd_x0",  0,    0, 0, 2'b10, 0, 0, 0, 1));

        // Bypass: rd!=rs1 reads old x1; rd==rs1 returns the write data same edge.
        issue(0, 32'h00108133, 1, K, mk("wr_x2", BEEF, BEEF, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h000080B3, 1, K, mk("bypass_x1", K, 0, 0, 2'b10, 0, 0, 0, 1));
        issue(0, 32'h00208133, 0, 0, mk("rd_x1_x2", K, K, 0, 2'b10, 0, 0, 0, 1));

        // Store, load, branches.
        issue(0, 32'hFE512E23, 0, 0, mk("sw",       K, 0, 32'hFFFFFFFC, 2'b00, 1, 1, 0, 0));
        issue(0, 32'h00812083, 0, 0, mk("lw",       K, 0, 32'h00000008, 2'b00, 1, 0, 1, 1));
        issue(0, 32'hFE208CE3, 0, 0, mk("beq-8",    K, K, 32'hFFFFFFF8, 2'b01, 0, 0, 0, 0));
        issue(0, 32'h00000463, 0, 0, mk("beq+8",    0, 0, 32'h00000008, 2'b01, 0, 0, 0, 0));
        issue(0, 32'h000000E3, 0, 0, mk("beq+2048", 0, 0, 32'h00000800, 2'b01, 0, 0, 0, 0));

        // Unknown opcode behaves as a bubble.
        issue(0, 32'h0000007F, 0, 0, mk("unknown", 0, 0, 0, 2'b00, 0, 0, 0, 0));

        // Mid-stream reset discards the instruction and clears the register file.
        issue(1, 32'h00208133, 0, 0, mk("reset_mid", 0, 0, 0, 2'b00, 0, 0, 0, 0));
        issue(0, 32'h00208133, 0, 0, mk("rd_after_reset", 0, 0, 0, 2'b10, 0, 0, 0, 1));

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
